mem_module: RTL

//  System-bus memory module: the slave directly downstream of the CPU bus master. Decodes
//  NB/address, serves single-word dr (read) / dw (write) transfers from inferred RAM, replies

---
 rtl/mem_module.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_module.sv
// System-bus memory slave: decodes segment/frame, serves single-word reads
// and writes from an inferred RAM with per-word odd parity, and answers on a
// 4-phase rok/ren/rpe handshake. Low offsets can be write-protected.
module mem_module #(
  parameter logic [3:0]  NB        = 4'd0,
  parameter int unsigned AW        = 12,
  parameter int unsigned BASE      = 0,
  parameter logic [15:0] WP_WORDS  = 16'd0,
  parameter logic [3:0]  ACC_TICKS = 4'd5
) (
  input  logic        __clk,
  input  logic        __rst_n,
  input  logic        dmcl,
  input  logic        dr,
  input  logic        dw,
  input  logic [3:0]  dnb,
  input  logic [0:15] dad,
  input  logic [15:0] ddt,
  input  logic        par_inj,
  output logic        rok,
  output logic        ren,
  output logic        rpe,
  output logic [15:0] rdt,
  output logic        busy
);

  localparam int unsigned FW = 16 - AW;

  typedef enum logic [1:0] {IDLE, WAIT, REPLY, RELEASE} state_t;

  state_t          state, state_nx;
  logic            op_wr;
  logic [AW-1:0]   off_q;
  logic [15:0]     data_q;
  logic            inj_q;
  logic [3:0]      cnt;
  logic [16:0]     mem [2**AW];

  logic [FW-1:0]   frame;
  logic [AW-1:0]   off;
  logic            hit;
  logic            req;
  logic            strobe_q;
  logic            access;
  logic            prot;
  logic [16:0]     word;

  // Address decode; dad bit 0 is the MSB, so the frame is the leading bits
  always_comb begin
    frame    = dad[0:FW-1];
    off      = dad[FW:15];
    hit      = (dnb == NB) && (frame == FW'(BASE));
    req      = hit && (dr ^ dw);
    strobe_q = op_wr ? dw : dr;
    access   = (state == WAIT) && (cnt == 4'd0);
    prot     = (16'(off_q) < WP_WORDS);
    word     = mem[off_q];
  end

  // State register
  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; master clear overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req)            state_nx = WAIT;
      WAIT:    if (cnt == 4'd0)    state_nx = REPLY;
      REPLY:   if (!strobe_q)      state_nx = RELEASE;
      RELEASE:                     state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
    if (dmcl) state_nx = IDLE;
  end

  // Request latch and access-delay counter
  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) begin
      op_wr  <= 1'b0;
      off_q  <= '0;
      data_q <= '0;
      inj_q  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && req && !dmcl) begin
      op_wr  <= dw;
      off_q  <= off;
      data_q <= ddt;
      inj_q  <= par_inj;
      cnt    <= ACC_TICKS;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Reply registers: set on access, held until the latched strobe drops
  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) begin
      rok <= 1'b0;
      ren <= 1'b0;
      rpe <= 1'b0;
      rdt <= '0;
    end else if (dmcl) begin
      rok <= 1'b0;
      ren <= 1'b0;
      rpe <= 1'b0;
      rdt <= '0;
    end else if (access) begin
      if (!op_wr) begin
        rdt <= word[16:1];
        rpe <= ~(^word);
        rok <= 1'b1;
      end else if (prot) begin
        ren <= 1'b1;
      end else begin
        rok <= 1'b1;
      end
    end else if (state == REPLY && !strobe_q) begin
      rok <= 1'b0;
      ren <= 1'b0;
      rpe <= 1'b0;
      rdt <= '0;
    end
  end

  // RAM write with odd parity; contents are not touched by reset
  always_ff @(posedge __clk) begin
    if (access && op_wr && !prot && !dmcl)
      mem[off_q] <= {data_q, (~(^data_q)) ^ inj_q};
  end

  // Busy flag
  always_comb busy = (state != IDLE);

endmodule
